// File: rtl/mem_bank_b_sequencer.sv
// mem_bank_b_sequencer
// Sequences the B-operand stream for a systolic array job. A job is m passes.
// Each pass restarts the B address generator, issues n*p beats as the array
// accepts them, and then checks the generator's beat count against n*p.
// Bad job parameters, or a beat-count mismatch, set a sticky error flag.
// A job that is already running keeps going to completion when an error is set.

module mem_bank_b_sequencer #(
    parameter int ARRAY_WIDTH      = 4,
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] n,
    input  logic [15:0] p,
    input  logic [15:0] m,
    input  logic        array_ready_i,
    input  logic [15:0] gen_count_i,
    output logic        gen_start_o,
    output logic        gen_valid_o,
    output logic        gen_clear_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    // Number of array-width element groups carried by one bus word.
    // Every row of B must occupy a whole number of bus words.
    localparam int BURST      = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES / ARRAY_WIDTH;
    localparam int BURST_LOG2 = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_RUN      = 3'd2,
        ST_PASS_END = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // State and latched job parameters
    state_t      state_q,     state_d;
    logic [15:0] n_q,         n_d;
    logic [15:0] p_q,         p_d;
    logic [15:0] m_q,         m_d;
    logic [31:0] beat_cnt_q,  beat_cnt_d;
    logic [15:0] pass_cnt_q,  pass_cnt_d;

    // Registered outputs
    logic        gen_start_q, gen_start_d;
    logic        gen_clear_q, gen_clear_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        error_q,     error_d;

    // Helper terms
    logic [31:0] beats_per_pass_s;
    logic        start_bad_s;
    logic        p_aligned_s;
    logic        last_beat_s;
    logic        count_mismatch_s;
    logic        last_pass_s;

    // Beats issued in each pass, computed from the latched parameters (full 32-bit product).
    assign beats_per_pass_s = {16'd0, n_q} * {16'd0, p_q};

    // p must be a multiple of BURST, so its low bits must all be zero.
    assign p_aligned_s = (p[BURST_LOG2-1:0] == {BURST_LOG2{1'b0}});

    // A start with any zero dimension or a misaligned p cannot run.
    assign start_bad_s = (n == 16'd0) | (p == 16'd0) | (m == 16'd0) | ~p_aligned_s;

    // This cycle issues the final beat of the pass.
    assign last_beat_s = (beat_cnt_q == 32'd1) & array_ready_i;

    // The generator should have counted exactly one pass worth of beats.
    assign count_mismatch_s = (gen_count_i != beats_per_pass_s[15:0]);

    // The pass that is ending is the last pass of the job.
    assign last_pass_s = (pass_cnt_q == 16'd1);

    // While running, the generator advances exactly when the array takes a beat.
    assign gen_valid_o = (state_q == ST_RUN) & array_ready_i;

    assign gen_start_o = gen_start_q;
    assign gen_clear_o = gen_clear_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

    // Next-state and next-output logic for the job sequencer.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        p_d         = p_q;
        m_d         = m_q;
        beat_cnt_d  = beat_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        error_d     = error_q;
        gen_start_d = 1'b0;
        gen_clear_d = 1'b0;
        done_d      = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d        = n;
                    p_d        = p;
                    m_d        = m;
                    pass_cnt_d = m;
                    if (start_bad_s) begin
                        // Reject the job: flag it and finish at once, with no generator activity.
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        error_d     = 1'b0;
                        gen_start_d = 1'b1;
                        state_d     = ST_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_INIT: begin
                beat_cnt_d = beats_per_pass_s;
                state_d    = ST_RUN;
            end

            ST_RUN: begin
                if (array_ready_i) begin
                    beat_cnt_d = beat_cnt_q - 32'd1;
                    if (last_beat_s) begin
                        gen_clear_d = 1'b1;
                        state_d     = ST_PASS_END;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    // The array stalled, so everything holds.
                    state_d = ST_RUN;
                end
            end

            ST_PASS_END: begin
                if (count_mismatch_s) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                pass_cnt_d = pass_cnt_q - 16'd1;
                if (last_pass_s) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    gen_start_d = 1'b1;
                    state_d     = ST_INIT;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                // An unreachable encoding was seen, so fall back to a safe idle.
                state_d = ST_IDLE;
            end
        endcase

        // busy_o is high for the whole of every pass and low otherwise.
        if ((state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_PASS_END)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State, counter, parameter and output registers. Reset is asynchronous and active high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= 16'd0;
            p_q         <= 16'd0;
            m_q         <= 16'd0;
            beat_cnt_q  <= 32'd0;
            pass_cnt_q  <= 16'd0;
            gen_start_q <= 1'b0;
            gen_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            p_q         <= p_d;
            m_q         <= m_d;
            beat_cnt_q  <= beat_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            gen_start_q <= gen_start_d;
            gen_clear_q <= gen_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_bank_b_sequencer.sv
// Directed testbench for mem_bank_b_sequencer. It uses the default parameters, so BURST = 8.
// Latency is counted with the start cycle as cycle 1. The done_o cycle must then
// be cycle m*(n*p+2)+2.

module tb_mem_bank_b_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i = 1'b0;
    logic [15:0] n_s = 16'd0;
    logic [15:0] p_s = 16'd0;
    logic [15:0] m_s = 16'd0;
    logic        array_ready_i = 1'b0;
    logic [15:0] gen_count_i;
    logic        gen_start_o, gen_valid_o, gen_clear_o, busy_o, done_o, error_o;

    int errors = 0;
    int checks = 0;

    // Counts taken from the DUT outputs, sampled on the rising edge.
    int n_start = 0, n_valid = 0, n_clear = 0, n_done = 0;
    int n_excl = 0, n_valid_noready = 0;

    // Stand-in for the B address generator. offset lets the bench corrupt the count it reports.
    logic [15:0] gen_model = 16'd0;
    logic [15:0] gen_offset = 16'd0;

    assign gen_count_i = gen_model + gen_offset;

    mem_bank_b_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .n             (n_s),
        .p             (p_s),
        .m             (m_s),
        .array_ready_i (array_ready_i),
        .gen_count_i   (gen_count_i),
        .gen_start_o   (gen_start_o),
        .gen_valid_o   (gen_valid_o),
        .gen_clear_o   (gen_clear_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gen_start_o || gen_clear_o) gen_model <= 16'd0;
        else if (gen_valid_o)           gen_model <= gen_model + 16'd1;
    end

    always @(posedge clk) begin
        if (gen_start_o) n_start++;
        if (gen_valid_o) n_valid++;
        if (gen_clear_o) n_clear++;
        if (done_o)      n_done++;
        if ((gen_start_o & gen_valid_o) | (gen_start_o & gen_clear_o) | (gen_valid_o & gen_clear_o)) n_excl++;
        if (gen_valid_o & ~array_ready_i) n_valid_noready++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run one job. mode 0 holds array_ready_i at 1. mode 1 toggles it, starting at 1 on the start cycle.
    // With poke set, a second start (with n=0) is issued while the job is busy. It must be ignored.
    task automatic run_job(input logic [15:0] nn, input logic [15:0] pp, input logic [15:0] mm,
                           input int mode, input bit poke, output int lat, output bit seen);
        lat  = 1;
        seen = 1'b0;
        n_s = nn; p_s = pp; m_s = mm;
        start_i = 1'b1;
        array_ready_i = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            lat++;
            start_i = 1'b0;
            if (poke && lat == 5) begin start_i = 1'b1; n_s = 16'd0; end
            if (poke && lat == 6) begin start_i = 1'b0; n_s = nn; end
            if (lat == 2) chk("init_start_busy", {30'd0, gen_start_o, busy_o}, 32'd3);
            if (mode == 1) array_ready_i = (lat % 2 == 1);
            if (done_o) begin seen = 1'b1; break; end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        array_ready_i = 1'b1;
    endtask

    initial begin
        int lat, s0, v0, c0, d0;
        bit seen;

        // Reset state
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("reset_outputs", {26'd0, gen_start_o, gen_valid_o, gen_clear_o, busy_o, done_o, error_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("idle_outputs", {26'd0, gen_start_o, gen_valid_o, gen_clear_o, busy_o, done_o, error_o}, 32'd0);

        // V-1: n=2, p=8, m=1, ready held high
        s0 = n_start; v0 = n_valid; c0 = n_clear; d0 = n_done;
        run_job(16'd2, 16'd8, 16'd1, 0, 1'b0, lat, seen);
        chk("v1_latency", 32'(lat), 32'd20);
        chk("v1_busy_in_done", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        chk("v1_starts", 32'(n_start - s0), 32'd1);
        chk("v1_beats", 32'(n_valid - v0), 32'd16);
        chk("v1_clears", 32'(n_clear - c0), 32'd1);
        chk("v1_done_one_cycle", {30'd0, done_o, 1'b0}, 32'd0);
        chk("v1_dones", 32'(n_done - d0), 32'd1);
        chk("v1_error", {31'd0, error_o}, 32'd0);

        // V-2: same job, ready toggling, so 16 beats take 31 RUN cycles and there are 15 stalls
        s0 = n_start; v0 = n_valid; d0 = n_done;
        run_job(16'd2, 16'd8, 16'd1, 1, 1'b0, lat, seen);
        chk("v2_latency", 32'(lat), 32'd35);
        @(posedge clk); #1;
        chk("v2_beats", 32'(n_valid - v0), 32'd16);
        chk("v2_valid_without_ready", 32'(n_valid_noready), 32'd0);
        chk("v2_dones", 32'(n_done - d0), 32'd1);

        // V-3: n=1, p=8, m=3, with an ignored start mid-job. Latency is 3*(8+2)+2 = 32
        s0 = n_start; v0 = n_valid; c0 = n_clear; d0 = n_done;
        run_job(16'd1, 16'd8, 16'd3, 0, 1'b1, lat, seen);
        chk("v3_latency", 32'(lat), 32'd32);
        @(posedge clk); #1;
        chk("v3_starts", 32'(n_start - s0), 32'd3);
        chk("v3_beats", 32'(n_valid - v0), 32'd24);
        chk("v3_clears", 32'(n_clear - c0), 32'd3);
        chk("v3_dones", 32'(n_done - d0), 32'd1);
        chk("v3_error", {31'd0, error_o}, 32'd0);

        // V-4: p=6 is rejected
        s0 = n_start; v0 = n_valid; c0 = n_clear;
        n_s = 16'd1; p_s = 16'd6; m_s = 16'd1; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("v4a_err_done_busy", {29'd0, error_o, done_o, busy_o}, 32'd6);
        @(posedge clk); #1;
        chk("v4a_after", {30'd0, error_o, done_o}, 32'd2);
        // n=0 is rejected
        n_s = 16'd0; p_s = 16'd8; m_s = 16'd1; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("v4b_err_done", {30'd0, error_o, done_o}, 32'd3);
        @(posedge clk); #1;
        chk("v4_no_gen", 32'((n_start - s0) + (n_valid - v0) + (n_clear - c0)), 32'd0);
        // A following valid start clears error_o
        n_s = 16'd1; p_s = 16'd8; m_s = 16'd1; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("v4_error_cleared", {30'd0, error_o, busy_o}, 32'd1);
        for (int k = 0; k < 40 && !done_o; k++) begin @(posedge clk); #1; end
        chk("v4_valid_job_done", {31'd0, done_o}, 32'd1);
        @(posedge clk); #1;

        // V-5: reset after 5 beats
        n_s = 16'd2; p_s = 16'd8; m_s = 16'd1; start_i = 1'b1; array_ready_i = 1'b1;
        v0 = n_valid;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 40 && (n_valid - v0) < 5; k++) begin @(posedge clk); #1; end
        chk("v5_beats_before_reset", 32'(n_valid - v0), 32'd5);
        reset = 1'b1;
        #1;
        chk("v5_outputs_zero", {26'd0, gen_start_o, gen_valid_o, gen_clear_o, busy_o, done_o, error_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        v0 = n_valid;
        run_job(16'd2, 16'd8, 16'd1, 0, 1'b0, lat, seen);
        chk("v5_latency", 32'(lat), 32'd20);
        @(posedge clk); #1;
        chk("v5_full_beats", 32'(n_valid - v0), 32'd16);

        // V-6: the generator reports 15 instead of 16
        gen_offset = 16'hFFFF;
        d0 = n_done;
        run_job(16'd2, 16'd8, 16'd1, 0, 1'b0, lat, seen);
        chk("v6_latency", 32'(lat), 32'd20);
        chk("v6_error_set", {31'd0, error_o}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("v6_error_held", {31'd0, error_o}, 32'd1);
        chk("v6_dones", 32'(n_done - d0), 32'd1);
        gen_offset = 16'd0;

        chk("gen_mutual_exclusion", 32'(n_excl), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bank_b_sequencer.md
MEM_BANK_B_SEQUENCER -- requirements
Module: mem_bank_b_sequencer

Interface
REQ-001 Parameter ARRAY_WIDTH, default 4: systolic array width in elements.
REQ-002 Parameter BUS_WIDTH_BYTES, default 32: memory bus width in bytes.
REQ-003 Parameter DATA_WIDTH_BYTES, default 1: element width in bytes.
REQ-004 Derived BURST = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES / ARRAY_WIDTH (default 8), a power of two, at least 2.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start_i  input  1  one-cycle job start request.
REQ-008 n  input  16  inner dimension; sampled only on an accepted start.
REQ-009 p  input  16  columns of B; sampled only on an accepted start.
REQ-010 m  input  16  pass count (row-blocks of A); sampled only on an accepted start.
REQ-011 array_ready_i  input  1  array can accept a B beat this cycle.
REQ-012 gen_count_i  input  16  beat count from the B address generator.
REQ-013 gen_start_o  output  1  restarts the address generator.
REQ-014 gen_valid_o  output  1  advances the address generator by one beat.
REQ-015 gen_clear_o  output  1  clears the generator beat count.
REQ-016 busy_o  output  1  job in progress.
REQ-017 done_o  output  1  one-cycle job completion pulse.
REQ-018 error_o  output  1  sticky error flag.

Function
REQ-019 The FSM SHALL have states IDLE, INIT, RUN, PASS_END and DONE, encoded in a single register.
REQ-020 In IDLE, start_i=1 SHALL latch n, p and m, clear error_o, and go to INIT; start_i in any other state SHALL be ignored.
REQ-021 On an accepted start, if n==0, p==0, m==0, or p is not a multiple of BURST, the block SHALL set error_o, pulse done_o next cycle and return to IDLE with no gen_* activity.
REQ-022 INIT SHALL last exactly one cycle with gen_start_o=1, load the 32-bit beat counter with n*p (full 32-bit product), and go to RUN.
REQ-023 In RUN, gen_valid_o SHALL equal array_ready_i (combinational), and the beat counter SHALL decrement by 1 on each cycle gen_valid_o=1.
REQ-024 The cycle that issues the last beat (counter==1 and array_ready_i=1) SHALL move the FSM to PASS_END; array_ready_i=0 SHALL hold all state.
REQ-025 PASS_END SHALL last one cycle with gen_clear_o=1, and SHALL compare gen_count_i with the low 16 bits of n*p; on a mismatch it SHALL set error_o.
REQ-026 PASS_END SHALL decrement the 16-bit pass counter (loaded with m); if the result is nonzero the FSM SHALL go to INIT, otherwise to DONE.
REQ-027 DONE SHALL assert done_o for exactly one cycle and return to IDLE.
REQ-028 busy_o SHALL be 1 in INIT, RUN and PASS_END, and 0 in IDLE and DONE.
REQ-029 gen_start_o, gen_valid_o and gen_clear_o SHALL be mutually exclusive, and all SHALL be 0 outside their stated states.
REQ-030 error_o SHALL remain set until the next accepted start or reset, and SHALL NOT abort a running job.
REQ-031 Minimum job latency from the accepted start to done_o SHALL be m*(n*p + 2) + 2 cycles with array_ready_i held at 1.

Reset
REQ-032 reset=1 SHALL force IDLE immediately at any time, including mid-job.
REQ-033 reset=1 SHALL clear all counters and latched parameters to 0, and drive every output to 0.
REQ-034 After reset deasserts, the first rising edge with start_i=1 SHALL be accepted.

Verification
V-1 n=2, p=8, m=1, array_ready_i=1: one gen_start_o, 16 consecutive gen_valid_o, one gen_clear_o, done_o 20 cycles after the start.
V-2 Same job with array_ready_i toggling 1/0: exactly 16 gen_valid_o pulses, each coinciding with array_ready_i=1; done_o is delayed by the number of stalled cycles.
V-3 n=1, p=8, m=3: three INIT-RUN-PASS_END sequences, 3 gen_start_o pulses, 24 beats total, one done_o.
V-4 p=6 (not a multiple of 8), or n=0: error_o=1, done_o pulse, gen_* never asserted; a following valid start clears error_o.
V-5 Reset asserted mid-RUN after 5 beats: outputs 0 within the same cycle; a new start after release runs the full beat count.
V-6 gen_count_i forced to 15 instead of 16 at PASS_END: error_o=1 and held; the job still completes with done_o.
